// File: rtl/secp256k1_jac_to_affine_if.sv
// Request/response and inverter-port bundle for the Jacobian-to-affine converter.
// The converter is the slave of the request side and drives the inverter request.
interface secp256k1_jac_to_affine_if;
    localparam int unsigned W = 256;

    logic         start;
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic [W-1:0] z_in;
    logic         busy;
    logic [W-1:0] x_out;
    logic [W-1:0] y_out;
    logic         done;
    logic         error;
    logic         inv_start;
    logic [W-1:0] inv_a;
    logic [W-1:0] inv_result;
    logic         inv_done;

    modport slave (
        input  start, x_in, y_in, z_in, inv_result, inv_done,
        output busy, x_out, y_out, done, error, inv_start, inv_a
    );

    modport master (
        output start, x_in, y_in, z_in, inv_result, inv_done,
        input  busy, x_out, y_out, done, error, inv_start, inv_a
    );
endinterface

// File: rtl/secp256k1_jac_to_affine.sv
// Converts a Jacobian secp256k1 point to affine: one external inversion of Z,
// then x = X*Zi^2 and y = Y*Zi^3 mod p on a shared bit-serial multiplier.
module secp256k1_jac_to_affine #(
    parameter int unsigned INV_TIMEOUT = 2048
) (
    input  logic                        clk,
    input  logic                        rst_n,
    secp256k1_jac_to_affine_if.slave    bus
);
    localparam int unsigned W  = 256;
    localparam int unsigned AW = 258;
    localparam int unsigned IW = 8;
    localparam int unsigned CW = $clog2(INV_TIMEOUT + 1);
    localparam logic [W-1:0]  P     = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [AW-1:0] P_EXT = AW'(P);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK_Z,
        S_INV_REQ,
        S_INV_WAIT,
        S_MUL_ZZ,
        S_MUL_X,
        S_MUL_ZZZ,
        S_MUL_Y,
        S_DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  x_r;
    logic [W-1:0]  y_r;
    logic [W-1:0]  z_r;
    logic [W-1:0]  zi;
    logic [W-1:0]  t;
    logic [W-1:0]  acc;
    logic [IW-1:0] idx;
    logic          mul_load;
    logic [CW-1:0] cnt;

    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          inv_start_q;
    logic [W-1:0]  inv_a_q;
    logic [W-1:0]  x_out_q;
    logic [W-1:0]  y_out_q;

    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [AW-1:0] sum;
    logic [AW-1:0] red1;
    logic [W-1:0]  step_res;

    // Operand routing for the four chained products.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            S_MUL_ZZ:  begin op_a = zi;  op_b = zi; end
            S_MUL_X:   begin op_a = x_r; op_b = t;  end
            S_MUL_ZZZ: begin op_a = t;   op_b = zi; end
            S_MUL_Y:   begin op_a = y_r; op_b = t;  end
            default:   ;
        endcase
    end

    // One MSB-first interleaved step: 2*acc + b[i]*a < 3p, so two conditional subtracts suffice.
    always_comb begin
        sum      = AW'({acc, 1'b0}) + (op_b[idx] ? AW'(op_a) : '0);
        red1     = (sum >= P_EXT) ? (sum - P_EXT) : sum;
        step_res = W'((red1 >= P_EXT) ? (red1 - P_EXT) : red1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            zi          <= '0;
            t           <= '0;
            acc         <= '0;
            idx         <= '0;
            mul_load    <= 1'b0;
            cnt         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            inv_start_q <= 1'b0;
            inv_a_q     <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
        end else begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            inv_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        x_r    <= bus.x_in;
                        y_r    <= bus.y_in;
                        z_r    <= bus.z_in;
                        busy_q <= 1'b1;
                        state  <= S_CHK_Z;
                    end
                end
                S_CHK_Z: begin
                    if (z_r == '0) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        inv_a_q     <= z_r;
                        inv_start_q <= 1'b1;
                        state       <= S_INV_REQ;
                    end
                end
                S_INV_REQ: begin
                    cnt   <= '0;
                    state <= S_INV_WAIT;
                end
                S_INV_WAIT: begin
                    if (bus.inv_done) begin
                        zi       <= bus.inv_result;
                        mul_load <= 1'b1;
                        state    <= S_MUL_ZZ;
                    end else if (cnt == CW'(INV_TIMEOUT - 1)) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_MUL_ZZ, S_MUL_X, S_MUL_ZZZ, S_MUL_Y: begin
                    if (mul_load) begin
                        acc      <= '0;
                        idx      <= IW'(W - 1);
                        mul_load <= 1'b0;
                    end else begin
                        acc <= step_res;
                        if (idx == '0) begin
                            mul_load <= 1'b1;
                            case (state)
                                S_MUL_ZZ:  begin t       <= step_res; state <= S_MUL_X;   end
                                S_MUL_X:   begin x_out_q <= step_res; state <= S_MUL_ZZZ; end
                                S_MUL_ZZZ: begin t       <= step_res; state <= S_MUL_Y;   end
                                default: begin
                                    y_out_q  <= step_res;
                                    done_q   <= 1'b1;
                                    mul_load <= 1'b0;
                                    state    <= S_DONE;
                                end
                            endcase
                        end else begin
                            idx <= idx - IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.inv_start = inv_start_q;
    assign bus.inv_a     = inv_a_q;
    assign bus.x_out     = x_out_q;
    assign bus.y_out     = y_out_q;
endmodule
